// File: rtl/pillar_pkg.sv
// rtl/pillar_pkg.sv - opcode, itype constants and immediate extraction for decode_rf
package pillar_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Code 0 is reserved for the idle/reset bundle.
    localparam logic [4:0] RTYPE   = 5'd1;
    localparam logic [4:0] ITYPE   = 5'd2;
    localparam logic [4:0] STYPE   = 5'd3;
    localparam logic [4:0] BTYPE   = 5'd4;
    localparam logic [4:0] LTYPE   = 5'd5;
    localparam logic [4:0] UTYPE   = 5'd6;
    localparam logic [4:0] JTYPE   = 5'd7;
    localparam logic [4:0] JRTYPE  = 5'd8;
    localparam logic [4:0] ILLEGAL = 5'd31;

    // Immediates are returned sign-extended to 32 bits; callers widen to XLEN.
    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file with x0 hardwired to zero
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/decode_rf.sv
// rtl/decode_rf.sv - decode stage with register file, RAW scoreboard and operand bypass
module decode_rf
    import pillar_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ir_valid_i,
    input  logic [31:0]     ir_i,
    output logic            ir_ready_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] ra_o,
    output logic [XLEN-1:0] rb_o,
    output logic [XLEN-1:0] pass_o,
    output logic [4:0]      itype_o,
    output logic [AW-1:0]   rd_o,
    output logic            rd_we_o,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [6:0]      opcode;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [AW-1:0]   rs1, rs2;
    logic [4:0]      cls;
    logic            use_rs1, use_rs2, use_rd;
    logic            legal;
    logic [XLEN-1:0] rf_rd1, rf_rd2, op1, op2;
    logic [XLEN-1:0] sx_i, sx_s, sx_b, sx_u, sx_j;
    logic            wb_hit1, wb_hit2, hazard, accept;
    logic [NREGS-1:0] busy, busy_nx;

    logic [XLEN-1:0] nx_ra, nx_rb, nx_pass;
    logic [4:0]      nx_itype;
    logic [AW-1:0]   nx_rd;
    logic            nx_we;

    assign opcode = ir_i[6:0];
    assign rs1_f  = ir_i[19:15];
    assign rs2_f  = ir_i[24:20];
    assign rd_f   = ir_i[11:7];
    assign rs1    = rs1_f[AW-1:0];
    assign rs2    = rs2_f[AW-1:0];

    assign sx_i = XLEN'($signed(imm_i(ir_i)));
    assign sx_s = XLEN'($signed(imm_s(ir_i)));
    assign sx_b = XLEN'($signed(imm_b(ir_i)));
    assign sx_u = XLEN'($signed(imm_u(ir_i)));
    assign sx_j = XLEN'($signed(imm_j(ir_i)));

    always_comb begin
        cls     = ILLEGAL;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OP_R:    begin cls = RTYPE;  use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            OP_I:    begin cls = ITYPE;  use_rs1 = 1'b1; use_rd = 1'b1; end
            OP_L:    begin cls = LTYPE;  use_rs1 = 1'b1; use_rd = 1'b1; end
            OP_S:    begin cls = STYPE;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_B:    begin cls = BTYPE;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_U:    begin cls = UTYPE;  use_rd = 1'b1; end
            OP_JAL:  begin cls = JTYPE;  use_rd = 1'b1; end
            OP_JALR: begin cls = JRTYPE; use_rs1 = 1'b1; use_rd = 1'b1; end
            default: ;
        endcase
        legal = (cls != ILLEGAL)
              && !(use_rs1 && {1'b0, rs1_f} >= NREGS_L)
              && !(use_rs2 && {1'b0, rs2_f} >= NREGS_L)
              && !(use_rd  && {1'b0, rd_f}  >= NREGS_L);
    end

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_valid_i),
        .waddr  (wb_rd_i),
        .wdata  (wb_data_i),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // A same-cycle write-back both unblocks the source and supplies its value when bypassing.
    assign wb_hit1 = (BYPASS != 0) && wb_valid_i && (wb_rd_i == rs1) && (rs1 != '0);
    assign wb_hit2 = (BYPASS != 0) && wb_valid_i && (wb_rd_i == rs2) && (rs2 != '0);
    assign op1     = wb_hit1 ? wb_data_i : rf_rd1;
    assign op2     = wb_hit2 ? wb_data_i : rf_rd2;

    assign hazard = legal && ((use_rs1 && busy[rs1] && !wb_hit1)
                           || (use_rs2 && busy[rs2] && !wb_hit2));

    assign ir_ready_o = !reset && !hazard && (!out_valid_o || out_ready_i);
    assign accept     = ir_valid_i && ir_ready_o;

    always_comb begin
        nx_ra    = '0;
        nx_rb    = '0;
        nx_pass  = '0;
        nx_itype = ILLEGAL;
        nx_rd    = '0;
        nx_we    = 1'b0;
        if (legal) begin
            nx_itype = cls;
            case (cls)
                RTYPE:         begin nx_ra = op1;  nx_rb = op2; end
                ITYPE, JRTYPE: begin nx_ra = op1;  nx_rb = sx_i; end
                LTYPE:         begin nx_ra = sx_i; nx_rb = op1; end
                STYPE:         begin nx_ra = sx_s; nx_rb = op1; nx_pass = op2; end
                BTYPE:         begin nx_ra = op1;  nx_rb = op2; nx_pass = sx_b; end
                UTYPE:         nx_ra = sx_u;
                JTYPE:         nx_pass = sx_j;
                default:       ;
            endcase
            if (use_rd) begin
                nx_rd = rd_f[AW-1:0];
                nx_we = (rd_f != 5'd0);
            end
        end
    end

    // Set after clear so a new claim on the register being retired wins.
    always_comb begin
        busy_nx = busy;
        if (wb_valid_i) begin
            busy_nx[wb_rd_i] = 1'b0;
        end
        if (accept && nx_we) begin
            busy_nx[nx_rd] = 1'b1;
        end
        busy_nx[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            ra_o        <= '0;
            rb_o        <= '0;
            pass_o      <= '0;
            itype_o     <= '0;
            rd_o        <= '0;
            rd_we_o     <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            ra_o        <= nx_ra;
            rb_o        <= nx_rb;
            pass_o      <= nx_pass;
            itype_o     <= nx_itype;
            rd_o        <= nx_rd;
            rd_we_o     <= nx_we;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_rf.sv
// tb/tb_decode_rf.sv - directed self-checking bench for decode_rf (bypass and no-bypass builds)
module tb_decode_rf;
    import pillar_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        ir_valid_a, ir_valid_b;
    logic        out_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        ready_a, ready_b, ov_a, ov_b, we_a, we_b;
    logic [31:0] ra_a, rb_a, pass_a, ra_b, rb_b, pass_b;
    logic [4:0]  itype_a, itype_b;
    logic [4:0]  rd_a;
    logic [3:0]  rd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_rf #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_dut_a (
        .clk(clk), .reset(reset), .ir_valid_i(ir_valid_a), .ir_i(ir), .ir_ready_o(ready_a),
        .out_valid_o(ov_a), .out_ready_i(out_ready), .ra_o(ra_a), .rb_o(rb_a), .pass_o(pass_a),
        .itype_o(itype_a), .rd_o(rd_a), .rd_we_o(we_a),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data)
    );

    decode_rf #(.XLEN(32), .NREGS(16), .BYPASS(0)) u_dut_b (
        .clk(clk), .reset(reset), .ir_valid_i(ir_valid_b), .ir_i(ir), .ir_ready_o(ready_b),
        .out_valid_o(ov_b), .out_ready_i(out_ready), .ra_o(ra_b), .rb_o(rb_b), .pass_o(pass_b),
        .itype_o(itype_b), .rd_o(rd_b), .rd_we_o(we_b),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd[3:0]), .wb_data_i(wb_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; ir = '0; ir_valid_a = 1'b0; ir_valid_b = 1'b0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        tick(); tick();
        check("rst_ready", ready_a, 0);
        check("rst_valid", ov_a, 0);
        check("rst_ra", ra_a, 0);
        check("rst_itype", itype_a, 0);
        check("rst_rd", rd_a, 0);
        check("rst_we", we_a, 0);
        reset = 1'b0;

        // preload x5, x6 then add x7,x5,x6
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234; tick();
        wb_rd = 5'd6; wb_data = 32'hFFFF_FFF0; tick();
        wb_valid = 1'b0;
        ir = 32'h0062_83B3; ir_valid_a = 1'b1; #1;
        check("add_ready", ready_a, 1);
        tick(); ir_valid_a = 1'b0;
        check("add_valid", ov_a, 1);
        check("add_ra", ra_a, 32'h0000_1234);
        check("add_rb", rb_a, 32'hFFFF_FFF0);
        check("add_itype", itype_a, RTYPE);
        check("add_rd", rd_a, 7);
        check("add_we", we_a, 1);

        ir = 32'hFFF0_0093; ir_valid_a = 1'b1; tick(); ir_valid_a = 1'b0;
        check("addi_ra", ra_a, 0);
        check("addi_rb", rb_a, 32'hFFFF_FFFF);
        check("addi_itype", itype_a, ITYPE);
        check("addi_rd", rd_a, 1);

        // RAW on x3 with bypass: accepted in the write-back cycle
        ir = 32'h0010_0193; ir_valid_a = 1'b1; tick();
        ir = 32'h0031_8233; #1;
        check("raw_a_blk0", ready_a, 0);
        tick();
        check("raw_a_blk1", ready_a, 0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55; #1;
        check("raw_a_byp_ready", ready_a, 1);
        tick(); wb_valid = 1'b0; ir_valid_a = 1'b0;
        check("raw_a_ra", ra_a, 32'h55);
        check("raw_a_rb", rb_a, 32'h55);
        check("raw_a_rd", rd_a, 4);

        // RAW on x3 without bypass: accepted one cycle after write-back
        ir = 32'h0010_0193; ir_valid_b = 1'b1; tick();
        ir = 32'h0031_8233; #1;
        check("raw_b_blk0", ready_b, 0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h66; #1;
        check("raw_b_blk_wb", ready_b, 0);
        tick(); wb_valid = 1'b0; #1;
        check("raw_b_ready", ready_b, 1);
        tick();
        check("raw_b_ra", ra_b, 32'h66);
        check("raw_b_rb", rb_b, 32'h66);

        // NREGS=16 index range and unknown opcode
        ir = 32'h000A_0093; tick();
        check("b_x20_itype", itype_b, ILLEGAL);
        check("b_x20_we", we_b, 0);
        check("b_x20_valid", ov_b, 1);
        check("b_x20_rb", rb_b, 0);
        ir = 32'h0000_007F; tick(); ir_valid_b = 1'b0;
        check("b_op7f_itype", itype_b, ILLEGAL);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD; tick(); wb_valid = 1'b0;
        ir = 32'h0000_0433; ir_valid_b = 1'b1; tick(); ir_valid_b = 1'b0;
        check("b_x0_ra", ra_b, 0);
        check("b_x0_itype", itype_b, RTYPE);
        check("b_x0_rd", rd_b, 8);

        // backpressure: bundle must hold for 3 cycles
        ir = 32'h0062_83B3; ir_valid_a = 1'b1; tick();
        out_ready = 1'b0; ir = 32'hFFF0_0093; #1;
        check("hold_ready0", ready_a, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", ov_a, 1);
            check("hold_ra", ra_a, 32'h0000_1234);
            check("hold_rb", rb_a, 32'hFFFF_FFF0);
            check("hold_ready", ready_a, 0);
        end
        out_ready = 1'b1; #1;
        check("release_ready", ready_a, 1);
        tick();
        check("release_itype", itype_a, ITYPE);
        check("release_rb", rb_a, 32'hFFFF_FFFF);

        // sw x6,8(x5)
        ir = 32'h0062_A423; tick();
        check("sw_ra", ra_a, 8);
        check("sw_rb", rb_a, 32'h0000_1234);
        check("sw_pass", pass_a, 32'hFFFF_FFF0);
        check("sw_itype", itype_a, STYPE);
        check("sw_we", we_a, 0);

        // jal x1,-4
        ir = 32'hFFDF_F0EF; tick();
        check("jal_pass", pass_a, 32'hFFFF_FFFC);
        check("jal_itype", itype_a, JTYPE);
        check("jal_ra", ra_a, 0);
        check("jal_we", we_a, 1);

        // reset while stalled on busy x3
        ir = 32'h0010_0193; tick();
        ir = 32'h0031_8233; #1;
        check("rst_stall_blk", ready_a, 0);
        reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h99; #1;
        check("rst_stall_ready", ready_a, 0);
        tick(); reset = 1'b0; wb_valid = 1'b0;
        check("rst_stall_valid", ov_a, 0);
        #1;
        check("rst_post_ready", ready_a, 1);
        tick(); ir_valid_a = 1'b0;
        check("rst_post_valid", ov_a, 1);
        check("rst_post_ra", ra_a, 0);
        check("rst_post_rb", rb_a, 0);
        check("rst_post_rd", rd_a, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
